// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MDop encodings, default latencies and the
// result bundle passed from the arithmetic core to the HI/LO holding logic.
package md_pkg;

    localparam logic [2:0] MdNone  = 3'b000;
    localparam logic [2:0] MdMult  = 3'b001;
    localparam logic [2:0] MdMultu = 3'b010;
    localparam logic [2:0] MdDiv   = 3'b011;
    localparam logic [2:0] MdDivu  = 3'b100;
    localparam logic [2:0] MdMthi  = 3'b101;
    localparam logic [2:0] MdMtlo  = 3'b110;

    localparam int unsigned MultCyclesDefault = 5;
    localparam int unsigned DivCyclesDefault  = 10;

    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_mult_op(logic [2:0] op);
        return (op == MdMult) || (op == MdMultu);
    endfunction

    function automatic logic is_div_op(logic [2:0] op);
        return (op == MdDiv) || (op == MdDivu);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 64-bit multiply / 32-bit divide on the latched operands.
// Signed divide works on magnitudes so the 0x80000000 / -1 case needs no special handling.
module md_core
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output md_result_t  res
);

    logic [63:0] a_sext;
    logic [63:0] b_sext;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_sext = {{32{a[31]}}, a};
    assign b_sext = {{32{b[31]}}, b};
    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = a_sext * b_sext;
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign a_neg  = (op == MdDiv) && a[31];
    assign b_neg  = (op == MdDiv) && b[31];
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_neg ? (32'd0 - b) : b;
    // Keeps the divider defined for B=0; that result is never written.
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res = '0;
        unique case (op)
            MdMult: begin
                res.wr = 1'b1;
                res.hi = prod_s[63:32];
                res.lo = prod_s[31:0];
            end
            MdMultu: begin
                res.wr = 1'b1;
                res.hi = prod_u[63:32];
                res.lo = prod_u[31:0];
            end
            MdDiv, MdDivu: begin
                res.wr = (b != 32'd0);
                res.hi = rem;
                res.lo = quot;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Accepts one operation when idle, stays busy for a fixed latency, then commits the result.
module mult_div
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MultCyclesDefault,
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDop,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    md_result_t core_res;

    md_core u_core (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (core_res)
    );

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            // Any start during busy is dropped entirely.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                if (core_res.wr) begin
                    hi_d = core_res.hi;
                    lo_d = core_res.lo;
                end
            end
        end else if (start) begin
            if (is_mult_op(MDop) || is_div_op(MDop)) begin
                a_d    = A;
                b_d    = B;
                op_d   = MDop;
                busy_d = 1'b1;
                cnt_d  = is_mult_op(MDop) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            end else if (MDop == MdMthi) begin
                hi_d = A;
            end else if (MDop == MdMtlo) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: stimulus pushes expected HI/LO and busy length per long op,
// a monitor pops and compares each time busy falls outside reset.
module tb_mult_div;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDop;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   busy_prev = 1'b0;
    int   busy_cnt = 0;

    mult_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .MDop  (MDop),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a falling busy outside reset is a completed operation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_prev = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) busy_cnt++;
            if (busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion", 64'(busy_cnt), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("op%0d_HI", e.id), 64'(HI), 64'(e.hi));
                    chk($sformatf("op%0d_LO", e.id), 64'(LO), 64'(e.lo));
                    chk($sformatf("op%0d_busy_cycles", e.id), 64'(busy_cnt), 64'(e.cycles));
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        MDop  = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        MDop  = 3'b000;
        // Scramble operands: results must come from the latched copies.
        A     = 32'h5A5A_A5A5;
        B     = 32'h0F0F_F0F0;
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc,
                        input int id);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.cycles = cyc;
        e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        if (busy) chk({name, "_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic long_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int cyc,
                           input int id, input logic [31:0] prev_hi);
        push(ehi, elo, cyc, id);
        issue(op, a, b);
        chk($sformatf("op%0d_busy_set", id), 64'(busy), 64'd1);
        @(negedge clk);
        chk($sformatf("op%0d_HI_hold", id), 64'(HI), 64'(prev_hi));
        wait_idle($sformatf("op%0d", id));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        MDop  = 3'b000;
        A     = '0;
        B     = '0;
        #12;
        chk("reset_HI", 64'(HI), 64'd0);
        chk("reset_LO", 64'(LO), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        long_op(3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 1, 32'h0);
        long_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 2, 32'hFFFF_FFFF);
        long_op(3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 3, 32'h1);
        long_op(3'b100, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 4, 32'hFFFF_FFFF);
        long_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 5, 32'hFFFF_FFFF);
        long_op(3'b100, 32'd100, 32'd7, 32'd2, 32'd14, 10, 6, 32'h0);
        long_op(3'b011, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 7, 32'd2);

        // mthi then mtlo on consecutive cycles.
        @(negedge clk);
        start = 1'b1;
        MDop  = 3'b101;
        A     = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_HI", 64'(HI), 64'h1234_5678);
        MDop  = 3'b110;
        A     = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        MDop  = 3'b000;
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_HI", 64'(HI), 64'h1234_5678);
        chk("mtlo_LO", 64'(LO), 64'h9ABC_DEF0);

        // MDop 000 and 111 are no-ops.
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            MDop  = (i == 0) ? 3'b000 : 3'b111;
            A     = 32'hDEAD_0000;
            B     = 32'h0000_BEEF;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk($sformatf("nop%0d_busy", i), 64'(busy), 64'd0);
            chk($sformatf("nop%0d_HILO", i), {HI, LO}, 64'h1234_5678_9ABC_DEF0);
        end

        // mtlo during busy must be ignored.
        push(32'h1, 32'h0, 5, 8);
        issue(3'b001, 32'h0001_0000, 32'h0001_0000);
        start = 1'b1;
        MDop  = 3'b110;
        A     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        MDop  = 3'b000;
        chk("busy_mtlo_LO", 64'(LO), 64'h9ABC_DEF0);
        chk("busy_mtlo_busy", 64'(busy), 64'd1);
        wait_idle("op8");

        // Reset in the middle of a divide.
        issue(3'b011, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_HI", 64'(HI), 64'd0);
        chk("abort_LO", 64'(LO), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_write", {HI, LO}, 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        long_op(3'b001, 32'd7, 32'd6, 32'h0, 32'd42, 5, 9, 32'h0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
